// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: function codes, flag bit positions
// and the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] FUN_ADD     = 4'b0000;
  localparam logic [3:0] FUN_SUB     = 4'b0001;
  localparam logic [3:0] FUN_MUL     = 4'b0010;
  localparam logic [3:0] FUN_DIV     = 4'b0011;
  localparam logic [3:0] FUN_AND     = 4'b0100;
  localparam logic [3:0] FUN_OR      = 4'b0101;
  localparam logic [3:0] FUN_NAND    = 4'b0110;
  localparam logic [3:0] FUN_NOR     = 4'b0111;
  localparam logic [3:0] FUN_XOR     = 4'b1000;
  localparam logic [3:0] FUN_XNOR    = 4'b1001;
  localparam logic [3:0] FUN_EQ      = 4'b1010;
  localparam logic [3:0] FUN_GT      = 4'b1011;
  localparam logic [3:0] FUN_LT      = 4'b1100;
  localparam logic [3:0] FUN_SHR     = 4'b1101;
  localparam logic [3:0] FUN_SHL     = 4'b1110;
  localparam logic [3:0] FUN_ILLEGAL = 4'b1111;

  localparam int unsigned FLAG_ARITH = 3;
  localparam int unsigned FLAG_LOGIC = 2;
  localparam int unsigned FLAG_CMP   = 1;
  localparam int unsigned FLAG_SHIFT = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by the pointer. Purely combinational.
module rr_arb2 (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_ptr,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt    = 2'b00;
    o_gnt[0] = i_en & i_req0 & (~i_req1 | ~i_ptr);
    o_gnt[1] = i_en & i_req1 & (~i_req0 | i_ptr);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared clocked ALU: round-robin issue, one
// operation in flight, response returned over a valid/ready channel.
module alu_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FUN_W   = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [DATA_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_B,
  input  logic [FUN_W-1:0]  REQ0_FUN,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [DATA_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_B,
  input  logic [FUN_W-1:0]  REQ1_FUN,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [FUN_W-1:0]  ALU_FUN,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic [3:0]        ALU_FLAGS,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [3:0]        RSP_FLAGS,
  output logic              RSP_ERR,
  output logic              BUSY,
  output logic [CNT_W-1:0]  OP_CNT
);

  import alu_pkg::*;

  localparam int unsigned LatW = 3;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_ptr;
  logic              r_id;
  logic [LatW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [FUN_W-1:0]  r_alu_fun;
  logic [DATA_W-1:0] r_rsp_data;
  logic [3:0]        r_rsp_flags;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_op_cnt;

  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_sel_id;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [FUN_W-1:0]  w_sel_fun;
  logic              w_illegal;

  // Requests are ignored while reset is asserted, even in IDLE.
  rr_arb2 u_rr_arb2 (
    .i_req0 (REQ0_VALID),
    .i_req1 (REQ1_VALID),
    .i_ptr  (r_ptr),
    .i_en   ((r_state == StIdle) & ~rst),
    .o_gnt  (w_gnt)
  );

  assign w_accept  = |w_gnt;
  assign w_sel_id  = w_gnt[1];
  assign w_sel_a   = w_sel_id ? REQ1_A : REQ0_A;
  assign w_sel_b   = w_sel_id ? REQ1_B : REQ0_B;
  assign w_sel_fun = w_sel_id ? REQ1_FUN : REQ0_FUN;
  assign w_illegal = (w_sel_fun == FUN_W'(FUN_ILLEGAL));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = w_illegal ? StResp : StWait;
      StWait:  if (r_cnt == '0) w_state_nxt = StResp;
      StResp:  if (RSP_READY) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
      r_op_cnt    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_id <= w_sel_id;
            // Illegal codes never reach the ALU; its inputs keep the last legal op.
            if (w_illegal) begin
              r_rsp_data  <= '0;
              r_rsp_flags <= '0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_alu_a   <= w_sel_a;
              r_alu_b   <= w_sel_b;
              r_alu_fun <= w_sel_fun;
              r_cnt     <= LatW'(ALU_LAT);
            end
          end
        end
        StWait: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - LatW'(1);
          end else begin
            r_rsp_data  <= ALU_OUT;
            r_rsp_flags <= ALU_FLAGS;
            r_rsp_err   <= 1'b0;
          end
        end
        StResp: begin
          if (RSP_READY) begin
            r_op_cnt <= r_op_cnt + CNT_W'(1);
            r_ptr    <= ~r_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign REQ0_READY = w_gnt[0];
  assign REQ1_READY = w_gnt[1];
  assign ALU_A      = r_alu_a;
  assign ALU_B      = r_alu_b;
  assign ALU_FUN    = r_alu_fun;
  assign RSP_VALID  = (r_state == StResp);
  assign RSP_ID     = r_id;
  assign RSP_DATA   = r_rsp_data;
  assign RSP_FLAGS  = r_rsp_flags;
  assign RSP_ERR    = r_rsp_err;
  assign BUSY       = (r_state != StIdle);
  assign OP_CNT     = r_op_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a one-cycle ALU stand-in
// and a behavioural model of arbitration order and responses.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic        REQ0_READY, REQ1_READY;
  logic [15:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic [3:0]  REQ0_FUN = '0, REQ1_FUN = '0;
  logic [15:0] ALU_A, ALU_B, ALU_OUT;
  logic [3:0]  ALU_FUN, ALU_FLAGS;
  logic        RSP_VALID, RSP_ID, RSP_ERR;
  logic        RSP_READY = 1'b0;
  logic [15:0] RSP_DATA;
  logic [3:0]  RSP_FLAGS;
  logic        BUSY;
  logic [15:0] OP_CNT;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  logic        prio = 1'b0;
  logic [3:0]  last_fun = '0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ0_FUN(REQ0_FUN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .REQ1_FUN(REQ1_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
    .RSP_FLAGS(RSP_FLAGS), .RSP_ERR(RSP_ERR), .BUSY(BUSY), .OP_CNT(OP_CNT)
  );

  // Returns {flags, result} of the 16-bit ALU for one operation.
  function automatic logic [19:0] alu_ref(input logic [3:0] fun, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  f;
    r = '0;
    f = '0;
    case (fun)
      FUN_ADD:  begin r = a + b;  f[FLAG_ARITH] = 1'b1; end
      FUN_SUB:  begin r = a - b;  f[FLAG_ARITH] = 1'b1; end
      FUN_MUL:  begin r = a * b;  f[FLAG_ARITH] = 1'b1; end
      FUN_DIV:  begin r = (b == 0) ? 16'd0 : a / b; f[FLAG_ARITH] = 1'b1; end
      FUN_AND:  begin r = a & b;  f[FLAG_LOGIC] = 1'b1; end
      FUN_OR:   begin r = a | b;  f[FLAG_LOGIC] = 1'b1; end
      FUN_NAND: begin r = ~(a & b); f[FLAG_LOGIC] = 1'b1; end
      FUN_NOR:  begin r = ~(a | b); f[FLAG_LOGIC] = 1'b1; end
      FUN_XOR:  begin r = a ^ b;  f[FLAG_LOGIC] = 1'b1; end
      FUN_XNOR: begin r = ~(a ^ b); f[FLAG_LOGIC] = 1'b1; end
      FUN_EQ:   begin r = (a == b) ? 16'd1 : 16'd0; f[FLAG_CMP] = 1'b1; end
      FUN_GT:   begin r = (a > b) ? 16'd2 : 16'd0;  f[FLAG_CMP] = 1'b1; end
      FUN_LT:   begin r = (a < b) ? 16'd3 : 16'd0;  f[FLAG_CMP] = 1'b1; end
      FUN_SHR:  begin r = a >> 1; f[FLAG_SHIFT] = 1'b1; end
      FUN_SHL:  begin r = a << 1; f[FLAG_SHIFT] = 1'b1; end
      default:  begin r = '0; f = '0; end
    endcase
    return {f, r};
  endfunction

  // ALU stand-in: one clock edge from operands to result.
  always_ff @(posedge clk) {ALU_FLAGS, ALU_OUT} <= alu_ref(ALU_FUN, ALU_A, ALU_B);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    RSP_READY  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt  = '0;
    prio     = 1'b0;
    last_fun = '0;
  endtask

  task automatic set_req(input logic id, input logic [3:0] fun, input logic [15:0] a,
                         input logic [15:0] b);
    if (id) begin
      REQ1_VALID = 1'b1; REQ1_FUN = fun; REQ1_A = a; REQ1_B = b;
    end else begin
      REQ0_VALID = 1'b1; REQ0_FUN = fun; REQ0_A = a; REQ0_B = b;
    end
  endtask

  task automatic issue(input logic id, input logic [3:0] fun, input logic [15:0] a,
                       input logic [15:0] b);
    set_req(id, fun, a, b);
    #1;
    check("issue_ready", id ? REQ1_READY : REQ0_READY, 1);
    @(posedge clk);
    #1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    if (fun != FUN_ILLEGAL) last_fun = fun;
  endtask

  // Called one step after the acceptance edge; latency counts from the request cycle.
  task automatic wait_rsp(input logic eid, input logic [15:0] edata, input logic [3:0] eflags,
                          input logic eerr, input int elat, input int stall);
    int n;
    n = 1;
    while (RSP_VALID !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (RSP_VALID !== 1'b1) begin
      check("rsp_timeout", RSP_VALID, 1);
    end else begin
      check("rsp_latency", n, elat);
      check("rsp_id", RSP_ID, eid);
      check("rsp_data", RSP_DATA, edata);
      check("rsp_flags", RSP_FLAGS, eflags);
      check("rsp_err", RSP_ERR, eerr);
      check("alu_fun_held", ALU_FUN, last_fun);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        check("stall_valid", RSP_VALID, 1);
        check("stall_id", RSP_ID, eid);
        check("stall_data", RSP_DATA, edata);
        check("stall_busy", BUSY, 1);
        check("stall_ready", {REQ1_READY, REQ0_READY}, 0);
      end
      RSP_READY = 1'b1;
      #1;
      check("hs_ready", {REQ1_READY, REQ0_READY}, 0);
      @(posedge clk);
      #1;
      RSP_READY = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      prio = ~eid;
      check("op_cnt", OP_CNT, exp_cnt);
      check("post_hs_valid", RSP_VALID, 0);
    end
  endtask

  initial begin
    logic [19:0] ref_v;
    logic        seen;
    int          pat;
    logic        win;
    logic [3:0]  fun;
    logic [15:0] a, b;

    // Reset state and single ADD
    do_reset();
    check("rst_busy", BUSY, 0);
    check("rst_valid", RSP_VALID, 0);
    check("rst_opcnt", OP_CNT, 0);
    check("rst_alu", {ALU_A, ALU_B, ALU_FUN}, 0);
    check("rst_rsp", {RSP_DATA, RSP_FLAGS, RSP_ERR, RSP_ID}, 0);
    issue(1'b0, FUN_ADD, 16'd15, 16'd10);
    check("alu_ab", {ALU_A, ALU_B}, {16'd15, 16'd10});
    wait_rsp(1'b0, 16'd25, 4'b1000, 1'b0, 3, 0);

    // Tie after reset: REQ0, then REQ1, then a fresh tie to REQ0
    do_reset();
    set_req(1'b0, FUN_SUB, 16'd15, 16'd10);
    set_req(1'b1, FUN_MUL, 16'd15, 16'd10);
    #1;
    check("tie_rdy", {REQ1_READY, REQ0_READY}, 2'b01);
    @(posedge clk);
    #1;
    REQ0_VALID = 1'b0;
    last_fun = FUN_SUB;
    check("busy_rdy1", REQ1_READY, 0);
    wait_rsp(1'b0, 16'd5, 4'b1000, 1'b0, 3, 0);
    check("next_rdy", {REQ1_READY, REQ0_READY}, 2'b10);
    @(posedge clk);
    #1;
    REQ1_VALID = 1'b0;
    last_fun = FUN_MUL;
    wait_rsp(1'b1, 16'h0096, 4'b1000, 1'b0, 3, 0);
    set_req(1'b0, FUN_ADD, 16'd1, 16'd2);
    set_req(1'b1, FUN_ADD, 16'd3, 16'd4);
    #1;
    check("tie2_rdy", {REQ1_READY, REQ0_READY}, 2'b01);
    @(posedge clk);
    #1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    last_fun = FUN_ADD;
    wait_rsp(1'b0, 16'd3, 4'b1000, 1'b0, 3, 0);

    // Backpressure with both requesters waiting
    issue(1'b1, FUN_XOR, 16'h00F0, 16'h0FF0);
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    wait_rsp(1'b1, 16'h0F00, 4'b0100, 1'b0, 3, 5);
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;

    // Illegal function code
    issue(1'b1, FUN_ILLEGAL, 16'd7, 16'd9);
    check("ill_alu_fun", ALU_FUN, FUN_XOR);
    wait_rsp(1'b1, 16'd0, 4'b0000, 1'b1, 1, 0);

    // Reset in WAIT
    issue(1'b0, FUN_ADD, 16'd1, 16'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0; prio = 1'b0; last_fun = '0;
    check("wrst_busy", BUSY, 0);
    check("wrst_valid", RSP_VALID, 0);
    check("wrst_opcnt", OP_CNT, 0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (RSP_VALID !== 1'b0) seen = 1'b1;
    end
    check("wrst_no_rsp", seen, 0);
    issue(1'b0, FUN_GT, 16'd29, 16'd21);
    wait_rsp(1'b0, 16'd2, 4'b0010, 1'b0, 3, 0);

    // Lone REQ1 back-to-back
    do_reset();
    issue(1'b1, FUN_AND, 16'b10011, 16'b01010);
    wait_rsp(1'b1, 16'd2, 4'b0100, 1'b0, 3, 0);
    issue(1'b1, FUN_OR, 16'b10011, 16'b01010);
    wait_rsp(1'b1, 16'b11011, 4'b0100, 1'b0, 3, 0);
    issue(1'b1, FUN_SHR, 16'b10011, 16'b01010);
    wait_rsp(1'b1, 16'b01001, 4'b0001, 1'b0, 3, 0);
    issue(1'b1, FUN_SHL, 16'b10011, 16'b01010);
    wait_rsp(1'b1, 16'b100110, 4'b0001, 1'b0, 3, 0);
    check("b2b_opcnt", OP_CNT, 4);

    // Randomized traffic against the model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      pat = $urandom_range(1, 3);
      fun = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = 16'($urandom);
      win = (pat == 3) ? prio : (pat == 2);
      if (pat[0]) set_req(1'b0, win ? 4'($urandom_range(0, 15)) : fun, a, b);
      if (pat[1]) set_req(1'b1, win ? fun : 4'($urandom_range(0, 15)), a, b);
      #1;
      check("rnd_rdy", {REQ1_READY, REQ0_READY}, win ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b0;
      if (fun == FUN_ILLEGAL) begin
        wait_rsp(win, 16'd0, 4'd0, 1'b1, 1, $urandom_range(0, 2));
      end else begin
        last_fun = fun;
        ref_v = alu_ref(fun, a, b);
        wait_rsp(win, ref_v[15:0], ref_v[19:16], 1'b0, 3, $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
